muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the operand and result width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 start  input  1  SHALL request an M-extension operation; it is sampled only in IDLE.
REQ-005 Funct3  input  3  SHALL select the operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op_a  input  DATA_W  SHALL carry the rs1 operand (multiplicand / dividend).
REQ-007 op_b  input  DATA_W  SHALL carry the rs2 operand (multiplier / divisor).
REQ-008 flush  input  1  SHALL abort any in-flight operation.
REQ-009 busy  output  1  SHALL be high while in MUL or DIV state.
REQ-010 stall  output  1  SHALL be combinational: (start AND state==IDLE) OR busy.
REQ-011 done  output  1  SHALL pulse high for exactly one cycle when result is valid.
REQ-012 result  output  DATA_W  SHALL hold the last completed result until the next accepted start.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-014 In IDLE, start=1 with Funct3[2]=0 SHALL latch operands and Funct3 and go to MUL; with Funct3[2]=1 it SHALL go to DIV.
REQ-015 start SHALL be ignored outside IDLE; operand changes after acceptance SHALL NOT affect the result.
REQ-016 MUL SHALL perform one shift-add step per cycle on operand magnitudes for exactly DATA_W cycles, then go to DONE.
REQ-017 DIV SHALL perform one restoring-division step per cycle for exactly DATA_W cycles, then go to DONE.
REQ-018 Latency: if start is accepted at edge T, done SHALL be high during cycle T+DATA_W+1 (33 cycles for DATA_W=32); DONE SHALL return to IDLE on the next edge.
REQ-019 Signedness: MULH and DIV/REM treat both operands as signed; MULHSU treats op_a as signed and op_b as unsigned; MULHU, DIVU and REMU treat both as unsigned; the final sign correction SHALL be applied in the transition to DONE.
REQ-020 MUL SHALL return product bits [DATA_W-1:0]; MULH, MULHSU and MULHU SHALL return bits [2*DATA_W-1:DATA_W] of the 2*DATA_W-bit product.
REQ-021 REM/REMU remainder sign SHALL follow the dividend; quotient truncates toward zero.
REQ-022 Divide by zero SHALL skip DIV and go directly to DONE: quotient all ones, remainder = op_a, with done at cycle T+1.
REQ-023 Signed overflow (op_a = most-negative, op_b = -1, DIV/REM) SHALL skip to DONE: quotient = op_a, remainder = 0, with done at cycle T+1.
REQ-024 flush in MUL, DIV or DONE SHALL force IDLE on the next edge with no done pulse; result SHALL keep its prior value.
REQ-025 flush and start together in IDLE: flush SHALL win and the request SHALL NOT be accepted.

Reset
REQ-026 While reset is high, the state SHALL become IDLE, busy=0, done=0, result=0, and all internal accumulators SHALL be cleared, including mid-operation.
REQ-027 reset SHALL take priority over flush and start.

Configuration
REQ-028 With the macro MULDIV_DIV_EN defined, the DIV state and all divide/remainder operations SHALL be built as specified.
REQ-029 Without MULDIV_DIV_EN, the DIV state SHALL be omitted; any start with Funct3[2]=1 SHALL go directly to DONE with result 0 and done at cycle T+1, and multiply behaviour SHALL be unchanged.

Verification
REQ-030 MUL: op_a=7, op_b=-3 -> done at T+33, result=0xFFFFFFEB; busy high for 32 cycles; stall high from the start cycle through the last busy cycle.
REQ-031 MULHU: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF -> result=0xFFFFFFFE; MULH with the same operands -> result=0x00000000.
REQ-032 DIV: op_a=-7, op_b=2 -> quotient 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU: op_a=100, op_b=0 -> 0xFFFFFFFF at T+1.
REQ-033 DIV: op_a=0x80000000, op_b=0xFFFFFFFF -> result=0x80000000 at T+1; REM with the same operands -> 0.
REQ-034 A second start during busy is ignored; flush at cycle T+10 -> IDLE at T+11, no done, result unchanged; reset at T+5 -> all outputs 0 next cycle.
REQ-035 Without MULDIV_DIV_EN: DIV with op_a=10, op_b=2 -> done at T+1 with result=0; MUL with op_a=3, op_b=4 -> result=12 at T+33.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M-style multiply/divide sequencer.
// One shift-add (MUL) or restoring-division (DIV) step per clock on operand
// magnitudes, DATA_W steps per operation; sign correction on entry to DONE.
// Divide/remainder support is built only when MULDIV_DIV_EN is defined;
// otherwise any Funct3[2]=1 request completes in one cycle with result 0.
//
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset
//   start   - operation request, sampled only in IDLE
//   Funct3  - 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//   op_a    - rs1 (multiplicand / dividend)
//   op_b    - rs2 (multiplier / divisor)
//   flush   - abort in-flight operation
//   busy    - high in MUL or DIV state
//   stall   - combinational: (start & IDLE) | busy
//   done    - one-cycle completion pulse
//   result  - last completed result
module muldiv_sequencer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        Funct3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] hi_q;     // product high half / partial remainder
    logic [DATA_W-1:0] lo_q;     // multiplier shifting out / dividend-quotient
    logic [DATA_W-1:0] mcand_q;  // multiplicand or divisor magnitude
    logic [1:0]        f3_q;
    logic              neg_q;    // negate product / quotient
    logic              accept;
    logic              last;

    // Operand signedness and magnitudes
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [DATA_W-1:0] mag_a, mag_b;

    always_comb begin
        a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) || (Funct3[2] && !Funct3[0]);
        b_signed = (Funct3 == 3'b001) || (Funct3[2] && !Funct3[0]);
        a_neg    = a_signed && op_a[DATA_W-1];
        b_neg    = b_signed && op_b[DATA_W-1];
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
    end

    assign accept = (state_q == S_IDLE) && start && !flush;
    assign last   = (cnt_q == LAST_CNT);

    // Shift-add step: add multiplicand when multiplier LSB set, then shift right
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   mul_hi_n, mul_lo_n, mul_res;
    logic [2*DATA_W-1:0] prod, prod_s;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : (DATA_W+1)'(0));
        mul_hi_n = mul_sum[DATA_W:1];
        mul_lo_n = {mul_sum[0], lo_q[DATA_W-1:1]};
        prod     = {mul_hi_n, mul_lo_n};
        prod_s   = neg_q ? -prod : prod;
        mul_res  = (f3_q == 2'b00) ? prod_s[DATA_W-1:0] : prod_s[2*DATA_W-1:DATA_W];
    end

`ifdef MULDIV_DIV_EN
    logic              rneg_q;   // remainder takes the dividend sign
    logic [DATA_W:0]   div_rs, div_diff;
    logic              div_ge, div_zero, div_ovf;
    logic [DATA_W-1:0] div_hi_n, div_lo_n, quo_s, rem_s, div_res, div_skip_res;

    // Restoring step: shift next dividend bit into remainder, subtract if it fits
    always_comb begin
        div_rs   = {hi_q, lo_q[DATA_W-1]};
        div_diff = div_rs - {1'b0, mcand_q};
        div_ge   = !div_diff[DATA_W];
        div_hi_n = div_ge ? div_diff[DATA_W-1:0] : div_rs[DATA_W-1:0];
        div_lo_n = {lo_q[DATA_W-2:0], div_ge};
        quo_s    = neg_q  ? -div_lo_n : div_lo_n;
        rem_s    = rneg_q ? -div_hi_n : div_hi_n;
        div_res  = f3_q[1] ? rem_s : quo_s;
    end

    // Early-out cases that bypass the iterative divider
    always_comb begin
        div_zero = (op_b == '0);
        div_ovf  = !Funct3[0] && (op_a == {1'b1, {(DATA_W-1){1'b0}}}) && (op_b == '1);
        if (div_zero) begin
            div_skip_res = Funct3[1] ? op_a : '1;
        end else begin
            div_skip_res = Funct3[1] ? '0 : op_a;
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!Funct3[2]) begin
                        state_d = S_MUL;
`ifdef MULDIV_DIV_EN
                    end else if (div_zero || div_ovf) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
`else
                    end else begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (last) begin
                    state_d = S_DONE;
                end
            end
`ifdef MULDIV_DIV_EN
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (last) begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        stall = 1'b0;
`ifdef MULDIV_DIV_EN
        busy  = (state_q == S_MUL) || (state_q == S_DIV);
`else
        busy  = (state_q == S_MUL);
`endif
        done  = (state_q == S_DONE);
        stall = (start && (state_q == S_IDLE)) || busy;
    end

    // Datapath: operand capture, iteration, result write on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            f3_q    <= '0;
            neg_q   <= 1'b0;
            result  <= '0;
`ifdef MULDIV_DIV_EN
            rneg_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_q <= '0;
                        f3_q  <= Funct3[1:0];
                        if (!Funct3[2]) begin
                            hi_q    <= '0;
                            lo_q    <= mag_b;
                            mcand_q <= mag_a;
                            neg_q   <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
                        end else if (div_zero || div_ovf) begin
                            result <= div_skip_res;
                        end else begin
                            hi_q    <= '0;
                            lo_q    <= mag_a;
                            mcand_q <= mag_b;
                            neg_q   <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                        end
`else
                        end else begin
                            result <= '0;
                        end
`endif
                    end
                end
                S_MUL: begin
                    hi_q  <= mul_hi_n;
                    lo_q  <= mul_lo_n;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last && !flush) begin
                        result <= mul_res;
                    end
                end
`ifdef MULDIV_DIV_EN
                S_DIV: begin
                    hi_q  <= div_hi_n;
                    lo_q  <= div_lo_n;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last && !flush) begin
                        result <= div_res;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer (DATA_W=32).
// Expected results come from a behavioural arithmetic model; they are queued
// when a request is driven and popped when done is seen.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         flush;
    logic [2:0]   funct3;
    logic [W-1:0] op_a, op_b;
    logic         busy, stall, done;
    logic [W-1:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_res_q[$];
    int           exp_lat_q[$];
    logic [W-1:0] last_res;

    muldiv_sequencer #(.DATA_W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_res(input logic [2:0] f3, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        sp  = '0;
        up  = '0;
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
`ifdef MULDIV_DIV_EN
            3'd4: begin
                if (b == '0) return '1;
                if (ovf) return a;
                sp = sa / sb;
                return sp[31:0];
            end
            3'd5: begin
                if (b == '0) return '1;
                up = ua / ub;
                return up[31:0];
            end
            3'd6: begin
                if (b == '0) return a;
                if (ovf) return '0;
                sp = sa % sb;
                return sp[31:0];
            end
            3'd7: begin
                if (b == '0) return a;
                up = ua % ub;
                return up[31:0];
            end
`endif
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        if (!f3[2]) return W + 1;
`ifdef MULDIV_DIV_EN
        if (b == '0) return 1;
        if (!f3[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return W + 1;
`else
        return 1;
`endif
    endfunction

    // Drive one request, optionally poke a second start mid-operation, check completion
    task automatic do_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit second);
        int           n;
        int           bsy;
        bit           stall_ok;
        logic [W-1:0] er;
        int           el;
        exp_res_q.push_back(model_res(f3, a, b));
        exp_lat_q.push_back(model_lat(f3, a, b));
        @(negedge clk);
        start = 1'b1; funct3 = f3; op_a = a; op_b = b;
        #1 check({tag, "_stall_req"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
        start  = 1'b0;
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
        n = 1; bsy = 0; stall_ok = 1'b1;
        while (!done && n < 200) begin
            if (busy) bsy++;
            if (busy && !stall) stall_ok = 1'b0;
            if (second && n == 5) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        er = exp_res_q.pop_front();
        el = exp_lat_q.pop_front();
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_res"}, 64'(result), 64'(er));
        check({tag, "_lat"}, 64'(n), 64'(el));
        if (el > 1) begin
            check({tag, "_busy_cycles"}, 64'(bsy), 64'(W));
            check({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
        end
        last_res = er;
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_idle"}, 64'(busy), 64'd0);
        check({tag, "_hold"}, 64'(result), 64'(er));
    endtask

    task automatic count_done(input string tag, input int cycles);
        int dn;
        dn = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) dn++;
        end
        check(tag, 64'(dn), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        last_res = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        @(negedge clk) reset = 1'b0;

        // Directed cases
        do_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1);
        do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op("mulhsu", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b1);
        do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op("divu0", 3'b101, 32'd100, 32'd0, 1'b0);
        do_op("rem0", 3'b110, 32'd55, 32'd0, 1'b0);
        do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("div10_2", 3'b100, 32'd10, 32'd2, 1'b0);
        do_op("mul3_4", 3'b000, 32'd3, 32'd4, 1'b0);

        // Flush mid-operation: no done, result unchanged
        @(negedge clk);
        start = 1'b1; funct3 = 3'b000; op_a = 32'd1234; op_b = 32'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_result", 64'(result), 64'(last_res));
        count_done("flush_nodone", 40);

        // Flush and start together in IDLE: request dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 64'(busy), 64'd0);
        count_done("flush_start_nodone", 40);
        check("flush_start_result", 64'(result), 64'(last_res));

        // Reset mid-operation clears everything
        @(negedge clk);
        start = 1'b1; funct3 = 3'b011; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        reset = 1'b0;
        last_res = '0;
        count_done("midrst_nodone", 40);

        // Random operations, including zero divisors
        for (int i = 0; i < 16; i++) begin
            logic [2:0]   rf;
            logic [W-1:0] ra, rb;
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 5 == 0) ? '0 : $urandom;
            do_op($sformatf("rnd%0d", i), rf, ra, rb, bit'(i % 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
